fifo_ptr_ctrl: RTL and testbench

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ptr_ctrl_ptr_counter.sv | 36 +++
 rtl/fifo_ptr_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer controller: occupancy state
// encoding and the default pointer width.
package fifo_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_t;

endpackage

// File: rtl/fifo_ptr_ctrl_ptr_counter.sv
// SIZE-bit wrapping address counter with enable and synchronous
// active-low reset. Natural binary overflow provides the modulo-DEPTH wrap.
module ptr_counter #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    output logic [SIZE-1:0] ptr_o
);

    localparam logic [SIZE-1:0] PTR_ONE = SIZE'(1);

    logic [SIZE-1:0] ptr_q;
    logic [SIZE-1:0] ptr_d;

    // Advance by one when enabled; DEPTH-1 rolls over to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = ptr_q + PTR_ONE;
        end
    end

    // Pointer register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer/occupancy controller. Generates read and write addresses,
// accept handshakes, occupancy count, threshold flags and sticky error
// flags for an external DEPTH-entry RAM. No fall-through: a read in EMPTY
// is refused even when a write arrives in the same cycle.
module fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int SIZE     = DEFAULT_SIZE,
    parameter int AF_LEVEL = (2 ** SIZE) - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic            clr_err,
    output logic [SIZE-1:0] w_pointer,
    output logic [SIZE-1:0] r_pointer,
    output logic            wr_ack,
    output logic            rd_ack,
    output logic [SIZE:0]   count,
    output logic            full,
    output logic            almost_full,
    output logic            almost_empty,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [SIZE:0] DEPTH_CNT = (SIZE + 1)'(2 ** SIZE);
    localparam logic [SIZE:0] LAST_CNT  = DEPTH_CNT - (SIZE + 1)'(1);
    localparam logic [SIZE:0] ONE_CNT   = (SIZE + 1)'(1);
    localparam logic [SIZE:0] AF_CNT    = (SIZE + 1)'(AF_LEVEL);
    localparam logic [SIZE:0] AE_CNT    = (SIZE + 1)'(AE_LEVEL);

    fifo_state_t   state_q, state_d;
    logic [SIZE:0] count_q, count_d;
    logic          full_q, full_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    // Accept handshakes: reads need data present; a write into FULL is
    // accepted only when a read frees a slot in the same cycle.
    always_comb begin
        rd_ack = rst_n && rd_en && (state_q != EMPTY);
        wr_ack = rst_n && wr_en && ((state_q != FULL) || rd_ack);
    end

    // Occupancy and state update; simultaneous accept leaves count as is.
    always_comb begin
        count_d = count_q;
        unique case ({wr_ack, rd_ack})
            2'b10:   count_d = count_q + ONE_CNT;
            2'b01:   count_d = count_q - ONE_CNT;
            default: count_d = count_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            EMPTY: begin
                if (wr_ack && !rd_ack) begin
                    state_d = PARTIAL;
                end
            end
            PARTIAL: begin
                if (rd_ack && !wr_ack && (count_q == ONE_CNT)) begin
                    state_d = EMPTY;
                end else if (wr_ack && !rd_ack && (count_q == LAST_CNT)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (rd_ack && !wr_ack) begin
                    state_d = PARTIAL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // Flags decoded from the next count so they line up with count itself;
    // a fresh error event takes priority over clr_err.
    always_comb begin
        full_d = (count_d == DEPTH_CNT);
        af_d   = (count_d >= AF_CNT);
        ae_d   = (count_d <= AE_CNT);

        ovf_d = ovf_q;
        if (wr_en && !wr_ack) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end

        unf_d = unf_q;
        if (rd_en && !rd_ack) begin
            unf_d = 1'b1;
        end else if (clr_err) begin
            unf_d = 1'b0;
        end
    end

    // Control registers; reset discards any occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            count_q <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Write and read address counters, each stepped by its own accept.
    ptr_counter #(.SIZE(SIZE)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (wr_ack),
        .ptr_o (w_pointer)
    );

    ptr_counter #(.SIZE(SIZE)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (rd_ack),
        .ptr_o (r_pointer)
    );

    assign count        = count_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl (SIZE=4, DEPTH=16): occupancy-level model plus
// directed sequences with hand-computed expectations.
module tb_fifo_ptr_ctrl;

    localparam int SIZE  = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = DEPTH - 2;
    localparam int AEL   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic            clr_err = 1'b0;
    logic [SIZE-1:0] w_pointer;
    logic [SIZE-1:0] r_pointer;
    logic            wr_ack;
    logic            rd_ack;
    logic [SIZE:0]   count;
    logic            full;
    logic            almost_full;
    logic            almost_empty;
    logic            overflow;
    logic            underflow;

    int n_total = 0;
    int n_pass  = 0;

    // Model state: plain occupancy arithmetic
    int m_cnt = 0;
    int m_wp  = 0;
    int m_rp  = 0;
    int m_ovf = 0;
    int m_unf = 0;
    bit m_ready = 1'b0;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.SIZE(SIZE), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .w_pointer    (w_pointer),
        .r_pointer    (r_pointer),
        .wr_ack       (wr_ack),
        .rd_ack       (rd_ack),
        .count        (count),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mdl_rd_ack(input int cnt);
        return (rst_n && rd_en && cnt > 0) ? 1 : 0;
    endfunction

    function automatic int mdl_wr_ack(input int cnt);
        return (rst_n && wr_en && (cnt < DEPTH || mdl_rd_ack(cnt) == 1)) ? 1 : 0;
    endfunction

    // Model advances on each rising edge from the inputs presented to it
    always @(posedge clk) begin
        int ra, wa;
        if (!rst_n) begin
            m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            ra = mdl_rd_ack(m_cnt);
            wa = mdl_wr_ack(m_cnt);
            m_cnt = m_cnt + wa - ra;
            if (wa == 1) m_wp = (m_wp + 1) % DEPTH;
            if (ra == 1) m_rp = (m_rp + 1) % DEPTH;
            if (wr_en && wa == 0) m_ovf = 1;
            else if (clr_err)     m_ovf = 0;
            if (rd_en && ra == 0) m_unf = 1;
            else if (clr_err)     m_unf = 0;
        end
    end

    // Compare every cycle on the falling edge, once reset has been seen
    always @(negedge clk) begin
        if (m_ready) begin
            chk("m_wr_ack",       int'(wr_ack),       mdl_wr_ack(m_cnt));
            chk("m_rd_ack",       int'(rd_ack),       mdl_rd_ack(m_cnt));
            chk("m_count",        int'(count),        m_cnt);
            chk("m_w_pointer",    int'(w_pointer),    m_wp);
            chk("m_r_pointer",    int'(r_pointer),    m_rp);
            chk("m_full",         int'(full),         (m_cnt == DEPTH) ? 1 : 0);
            chk("m_almost_full",  int'(almost_full),  (m_cnt >= AFL) ? 1 : 0);
            chk("m_almost_empty", int'(almost_empty), (m_cnt <= AEL) ? 1 : 0);
            chk("m_overflow",     int'(overflow),     m_ovf);
            chk("m_underflow",    int'(underflow),    m_unf);
        end
    end

    // Present one input vector, let one rising edge consume it, return at edge+1
    task automatic drive(input bit w, input bit r, input bit c, input bit n);
        wr_en = w; rd_en = r; clr_err = c; rst_n = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_count",  int'(count), 0);
        chk("rst_ae",     int'(almost_empty), 1);
        chk("rst_full",   int'(full), 0);
        chk("rst_wptr",   int'(w_pointer), 0);

        // Fill 16 from reset
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 1);
            if (i == 12) chk("af_at_13", int'(almost_full), 0);
            if (i == 13) chk("af_at_14", int'(almost_full), 1);
        end
        chk("fill_wptr",  int'(w_pointer), 0);
        chk("fill_rptr",  int'(r_pointer), 0);
        chk("fill_count", int'(count), 16);
        chk("fill_full",  int'(full), 1);

        // 17th write refused, then cleared
        wr_en = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        #1;
        chk("ovf_wr_ack", int'(wr_ack), 0);
        drive(1, 0, 0, 1);
        chk("ovf_set",  int'(overflow), 1);
        chk("ovf_wptr", int'(w_pointer), 0);
        drive(0, 0, 1, 1);
        chk("ovf_clr",  int'(overflow), 0);

        // Simultaneous read/write while FULL
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 1);
        chk("fullrw_count", int'(count), 16);
        chk("fullrw_wptr",  int'(w_pointer), 3);
        chk("fullrw_rptr",  int'(r_pointer), 3);
        chk("fullrw_full",  int'(full), 1);

        // Underflow from EMPTY
        drive(0, 0, 0, 0);
        rd_en = 1'b1; rst_n = 1'b1;
        #1;
        chk("unf_rd_ack", int'(rd_ack), 0);
        drive(0, 1, 0, 1);
        chk("unf_set",  int'(underflow), 1);
        chk("unf_rptr", int'(r_pointer), 0);
        // New error in the same cycle beats clr_err
        drive(0, 1, 1, 1);
        chk("unf_wins_clr", int'(underflow), 1);
        drive(0, 0, 1, 1);
        chk("unf_clr", int'(underflow), 0);
        // Write and read together in EMPTY: write only
        drive(1, 1, 0, 1);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_wptr",  int'(w_pointer), 1);
        chk("empty_rw_rptr",  int'(r_pointer), 0);
        chk("empty_rw_unf",   int'(underflow), 1);

        // Write 5 / read 5, four rounds across the wrap
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 5; i++) drive(1, 0, 0, 1);
            for (int i = 0; i < 5; i++) drive(0, 1, 0, 1);
        end
        chk("wrap_wptr",  int'(w_pointer), 4);
        chk("wrap_rptr",  int'(r_pointer), 4);
        chk("wrap_count", int'(count), 0);
        chk("wrap_ae",    int'(almost_empty), 1);

        // Mixed pattern: drain to 1 via the PARTIAL->EMPTY edge and back
        drive(1, 0, 0, 1);
        drive(1, 0, 0, 1);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 1);
        chk("mix_count", int'(count), 1);
        drive(0, 1, 0, 1);
        chk("mix_empty", int'(count), 0);

        // Reset at count 7 with requests held
        for (int i = 0; i < 7; i++) drive(1, 0, 0, 1);
        chk("pre_rst_count", int'(count), 7);
        wr_en = 1'b1; rd_en = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_rd_ack", int'(rd_ack), 0);
        drive(1, 1, 0, 0);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_wptr",  int'(w_pointer), 0);
        chk("mid_rst_rptr",  int'(r_pointer), 0);
        chk("mid_rst_ae",    int'(almost_empty), 1);
        chk("mid_rst_af",    int'(almost_full), 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
